// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer: function classes,
// FSM state encoding and the ALU function codes.
package alu_seq_pkg;

  localparam logic [1:0] CLS_ARITH = 2'b00;
  localparam logic [1:0] CLS_LOGIC = 2'b01;
  localparam logic [1:0] CLS_CMP   = 2'b10;
  localparam logic [1:0] CLS_SHIFT = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } seq_state_e;

  localparam logic [3:0] FUN_ADD     = 4'd0;
  localparam logic [3:0] FUN_SUB     = 4'd1;
  localparam logic [3:0] FUN_MUL     = 4'd2;
  localparam logic [3:0] FUN_DIV     = 4'd3;
  localparam logic [3:0] FUN_AND     = 4'd4;
  localparam logic [3:0] FUN_OR      = 4'd5;
  localparam logic [3:0] FUN_NAND    = 4'd6;
  localparam logic [3:0] FUN_NOR     = 4'd7;
  localparam logic [3:0] FUN_CMP_NOP = 4'd8;
  localparam logic [3:0] FUN_CMP_EQ  = 4'd9;
  localparam logic [3:0] FUN_CMP_GT  = 4'd10;
  localparam logic [3:0] FUN_CMP_LT  = 4'd11;
  localparam logic [3:0] FUN_SHR_A   = 4'd12;
  localparam logic [3:0] FUN_SHL_A   = 4'd13;
  localparam logic [3:0] FUN_SHR_B   = 4'd14;
  localparam logic [3:0] FUN_SHL_B   = 4'd15;

  function automatic logic [1:0] fun_class(input logic [3:0] fun);
    return fun[3:2];
  endfunction

endpackage

// File: rtl/alu_result_sel.sv
// Maps a function class to the ALU unit flag that must be seen, that unit's
// result bus and the carry to report (carry only meaningful for arithmetic).
module alu_result_sel
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [1:0]       cls,
  input  logic [WIDTH-1:0] arith_out,
  input  logic [WIDTH-1:0] logic_out,
  input  logic [WIDTH-1:0] cmp_out,
  input  logic [WIDTH-1:0] shift_out,
  input  logic             carry_in,
  input  logic             arith_flag,
  input  logic             logic_flag,
  input  logic             cmp_flag,
  input  logic             shift_flag,
  output logic             flag,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  always_comb begin
    flag   = 1'b0;
    result = '0;
    carry  = 1'b0;
    case (cls)
      CLS_ARITH: begin
        flag   = arith_flag;
        result = arith_out;
        carry  = carry_in;
      end
      CLS_LOGIC: begin
        flag   = logic_flag;
        result = logic_out;
      end
      CLS_CMP: begin
        flag   = cmp_flag;
        result = cmp_out;
      end
      default: begin
        flag   = shift_flag;
        result = shift_out;
      end
    endcase
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issues one command at a time to the registered ALU, waits for the selected
// unit's flag (or a timeout) and returns a single response word.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int LAT     = 1,
  parameter int TIMEOUT = 8
) (
  input  logic             Clk,
  input  logic             RST,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_A,
  input  logic [WIDTH-1:0] cmd_B,
  input  logic [3:0]       cmd_FUN,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [3:0]       ALU_FUN,
  input  logic [WIDTH-1:0] Arith_OUT,
  input  logic [WIDTH-1:0] Logic_OUT,
  input  logic [WIDTH-1:0] CMP_OUT,
  input  logic [WIDTH-1:0] SHIFT_OUT,
  input  logic             Carry_OUT,
  input  logic             Arith_Flag,
  input  logic             Logic_Flag,
  input  logic             CMP_Flag,
  input  logic             SHIFT_Flag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_carry,
  output logic             rsp_err,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  // Handshake: a transfer happens on a rising Clk edge where valid and ready
  // are both high; valid never depends on ready, and cmd_ready/rsp_valid are
  // mutually exclusive because they decode different states.

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAT_C = CW'(LAT);
  localparam logic [CW-1:0] TO_C  = CW'(TIMEOUT);

  seq_state_e       state, state_nxt;
  logic [CW-1:0]    wait_cnt;
  logic             accept, capture, expire;
  logic             sel_flag, sel_carry;
  logic [WIDTH-1:0] sel_result;

  alu_result_sel #(.WIDTH(WIDTH)) u_sel (
    .cls        (fun_class(ALU_FUN)),
    .arith_out  (Arith_OUT),
    .logic_out  (Logic_OUT),
    .cmp_out    (CMP_OUT),
    .shift_out  (SHIFT_OUT),
    .carry_in   (Carry_OUT),
    .arith_flag (Arith_Flag),
    .logic_flag (Logic_Flag),
    .cmp_flag   (CMP_Flag),
    .shift_flag (SHIFT_Flag),
    .flag       (sel_flag),
    .result     (sel_result),
    .carry      (sel_carry)
  );

  always_ff @(posedge Clk or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    expire    = 1'b0;
    case (state)
      IDLE: if (cmd_valid) begin
        accept    = 1'b1;
        state_nxt = WAIT;
      end
      // Before LAT edges have passed the ALU outputs still belong to the old op.
      WAIT: if (wait_cnt >= LAT_C && sel_flag) begin
        capture   = 1'b1;
        state_nxt = RESP;
      end else if (wait_cnt == TO_C) begin
        expire    = 1'b1;
        state_nxt = RESP;
      end
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge RST) begin
    if (!RST) begin
      A         <= '0;
      B         <= '0;
      ALU_FUN   <= '0;
      wait_cnt  <= '0;
      rsp_data  <= '0;
      rsp_carry <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        A        <= cmd_A;
        B        <= cmd_B;
        ALU_FUN  <= cmd_FUN;
        wait_cnt <= '0;
      end else if (state == WAIT && wait_cnt != TO_C) begin
        wait_cnt <= wait_cnt + CW'(1);
      end
      if (capture) begin
        rsp_data  <= sel_result;
        rsp_carry <= sel_carry;
        rsp_err   <= 1'b0;
      end else if (expire) begin
        rsp_data  <= '0;
        rsp_carry <= 1'b0;
        rsp_err   <= 1'b1;
      end
    end
  end

  assign cmd_ready = (state == IDLE) && RST;
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: a behavioural registered ALU as load, directed
// scenarios plus random traffic, scoreboard with latency and data checks.
`timescale 1ns/1ps
module tb_alu_cmd_sequencer;
  import alu_seq_pkg::*;

  localparam int W       = 16;
  localparam int LAT     = 1;
  localparam int TIMEOUT = 8;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  logic RST = 1'b0;
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic         cmd_valid = 1'b0;
  logic [W-1:0] cmd_A = '0, cmd_B = '0;
  logic [3:0]   cmd_FUN = '0;
  logic         cmd_ready;
  logic [W-1:0] A, B;
  logic [3:0]   ALU_FUN;
  logic [W-1:0] Arith_OUT = '0, Logic_OUT = '0, CMP_OUT = '0, SHIFT_OUT = '0;
  logic         Carry_OUT = 1'b0;
  logic         af = 1'b0, lf = 1'b0, cf = 1'b0, sf = 1'b0;
  logic         Arith_Flag, Logic_Flag, CMP_Flag, SHIFT_Flag;
  logic         rsp_valid, rsp_ready, rsp_carry, rsp_err, busy;
  logic [W-1:0] rsp_data;
  logic [1:0]   state_dbg;

  // 0: real flags, 1: all flags 0, 2: only Arith_Flag forced 1
  int   force_mode = 0;
  logic rand_rdy = 1'b0, rr_rand = 1'b1, rr_man = 1'b1;

  assign Arith_Flag = (force_mode == 0) ? af : (force_mode == 2);
  assign Logic_Flag = (force_mode == 0) ? lf : 1'b0;
  assign CMP_Flag   = (force_mode == 0) ? cf : 1'b0;
  assign SHIFT_Flag = (force_mode == 0) ? sf : 1'b0;
  assign rsp_ready  = rand_rdy ? rr_rand : rr_man;

  alu_cmd_sequencer #(.WIDTH(W), .LAT(LAT), .TIMEOUT(TIMEOUT)) dut (
    .Clk(Clk), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_A(cmd_A), .cmd_B(cmd_B), .cmd_FUN(cmd_FUN),
    .A(A), .B(B), .ALU_FUN(ALU_FUN),
    .Arith_OUT(Arith_OUT), .Logic_OUT(Logic_OUT), .CMP_OUT(CMP_OUT), .SHIFT_OUT(SHIFT_OUT),
    .Carry_OUT(Carry_OUT),
    .Arith_Flag(Arith_Flag), .Logic_Flag(Logic_Flag), .CMP_Flag(CMP_Flag), .SHIFT_Flag(SHIFT_Flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_err(rsp_err),
    .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- ALU arithmetic: {carry, result} ----------------
  function automatic logic [W:0] alu_calc(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [3:0] f);
    logic [W:0] r;
    r = '0;
    case (f)
      FUN_ADD:     r = {1'b0, a} + {1'b0, b};
      FUN_SUB:     r = {1'b0, a} - {1'b0, b};
      FUN_MUL:     r = {1'b0, W'(a * b)};
      FUN_DIV:     r = (b == '0) ? '0 : {1'b0, a / b};
      FUN_AND:     r = {1'b0, a & b};
      FUN_OR:      r = {1'b0, a | b};
      FUN_NAND:    r = {1'b0, ~(a & b)};
      FUN_NOR:     r = {1'b0, ~(a | b)};
      FUN_CMP_NOP: r = '0;
      FUN_CMP_EQ:  r = (a == b) ? (W+1)'(1) : '0;
      FUN_CMP_GT:  r = (a > b)  ? (W+1)'(2) : '0;
      FUN_CMP_LT:  r = (a < b)  ? (W+1)'(3) : '0;
      FUN_SHR_A:   r = {1'b0, a >> 1};
      FUN_SHL_A:   r = {1'b0, a << 1};
      FUN_SHR_B:   r = {1'b0, b >> 1};
      default:     r = {1'b0, b << 1};
    endcase
    return r;
  endfunction

  // Registered ALU load: one edge of latency; Carry_OUT only moves on arith ops.
  logic [W:0] alu_r;
  assign alu_r = alu_calc(A, B, ALU_FUN);
  always @(posedge Clk) begin
    af <= 1'b0; lf <= 1'b0; cf <= 1'b0; sf <= 1'b0;
    case (ALU_FUN[3:2])
      2'b00: begin Arith_OUT <= alu_r[W-1:0]; Carry_OUT <= alu_r[W]; af <= 1'b1; end
      2'b01: begin Logic_OUT <= alu_r[W-1:0]; lf <= 1'b1; end
      2'b10: begin CMP_OUT   <= alu_r[W-1:0]; cf <= 1'b1; end
      default: begin SHIFT_OUT <= alu_r[W-1:0]; sf <= 1'b1; end
    endcase
  end

  // ---------------- reference model ----------------
  function automatic bit ref_err(input logic [3:0] f, input int mode);
    return (mode == 1) || (mode == 2 && f[3:2] != 2'b00);
  endfunction

  function automatic logic [W+1:0] ref_rsp(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [3:0] f, input int mode);
    logic [W:0] r;
    r = alu_calc(a, b, f);
    if (ref_err(f, mode)) return {1'b1, 1'b0, {W{1'b0}}};
    return {1'b0, (f[3:2] == 2'b00) ? r[W] : 1'b0, r[W-1:0]};
  endfunction

  // ---------------- scoreboard ----------------
  int total = 0, bad = 0;
  logic [W+1:0] exp_q[$];
  logic [W+1:0] got_q[$];
  int acc_q[$];
  int lat_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic       prev_valid = 1'b0;
  int         mon_acc, mon_lat;
  logic [W+1:0] mon_exp;
  always @(negedge Clk) begin
    if (RST) begin
      if (rsp_valid && !prev_valid) begin
        total++;
        if (acc_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 want no response (t=%0t)", $time);
        end else begin
          mon_acc = acc_q.pop_front();
          mon_lat = lat_q.pop_front();
          if (cyc - mon_acc != mon_lat) begin
            bad++;
            $display("FAIL latency: got=%0d want=%0d cycles", cyc - mon_acc, mon_lat);
          end
        end
      end
      if (rsp_valid && rsp_ready && exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        got_q.push_back({rsp_err, rsp_carry, rsp_data});
        chk("rsp_word", {rsp_err, rsp_carry, rsp_data}, mon_exp);
      end
      if (busy) chk("ready_while_busy", cmd_ready, 1'b0);
      if (rsp_valid) chk("valid_and_ready_excl", cmd_ready, 1'b0);
    end
    prev_valid = RST && rsp_valid;
  end

  initial forever begin
    @(posedge Clk); #1;
    rr_rand = ($urandom_range(0, 3) != 0);
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge Clk); #1;
    RST = 1'b0; cmd_valid = 1'b0; rand_rdy = 1'b0; rr_man = 1'b1; force_mode = 0;
    #1;
    chk("reset_outputs",
        {A, B, ALU_FUN, rsp_data, rsp_carry, rsp_err, rsp_valid, busy, cmd_ready, state_dbg},
        '0);
    repeat (2) @(posedge Clk);
    #1 RST = 1'b1;
    exp_q.delete(); got_q.delete(); acc_q.delete(); lat_q.delete();
    #1 chk("ready_after_reset", cmd_ready, 1'b1);
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] f,
                      input bit track);
    int n;
    @(posedge Clk); #1;
    cmd_valid = 1'b1; cmd_A = a; cmd_B = b; cmd_FUN = f;
    n = 0;
    do begin @(negedge Clk); n++; end while (!cmd_ready && n < 200);
    if (!cmd_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout: got cmd_ready=0 want 1 within 200 cycles");
      cmd_valid = 1'b0;
      return;
    end
    @(posedge Clk); #1;
    cmd_valid = 1'b0;
    if (track) begin
      exp_q.push_back(ref_rsp(a, b, f, force_mode));
      acc_q.push_back(cyc);
      lat_q.push_back(ref_err(f, force_mode) ? TIMEOUT + 1 : LAT + 1);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin @(negedge Clk); n++; end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int n;
    logic [3:0] f;

    // 1: single ADD
    do_reset();
    send(16'h000E, 16'h0007, FUN_ADD, 1'b1);
    drain();
    chk("add_result", got_q[0], {2'b00, 16'h0015});

    // 2: back-to-back MUL, CMP-eq, SHR-A
    do_reset();
    send(16'h000E, 16'h0007, FUN_MUL, 1'b1);
    send(16'h000A, 16'h000A, FUN_CMP_EQ, 1'b1);
    send(16'h000C, 16'h0000, FUN_SHR_A, 1'b1);
    drain();
    chk("seq_mul", got_q[0], {2'b00, 16'h0062});
    chk("seq_cmp", got_q[1], {2'b00, 16'h0001});
    chk("seq_shr", got_q[2], {2'b00, 16'h0006});

    // 3: backpressure with a pending command
    do_reset();
    rr_man = 1'b0;
    send(16'h000E, 16'h0007, FUN_ADD, 1'b1);
    n = 0;
    while (!rsp_valid && n < 50) begin @(negedge Clk); n++; end
    chk("bp_valid", rsp_valid, 1'b1);
    @(posedge Clk); #1;
    cmd_valid = 1'b1; cmd_A = 16'h1234; cmd_B = 16'h0001; cmd_FUN = FUN_SUB;
    repeat (5) begin
      @(negedge Clk);
      chk("bp_data", {rsp_err, rsp_carry, rsp_data}, {2'b00, 16'h0015});
      chk("bp_state", {busy, cmd_ready, rsp_valid}, 3'b101);
      chk("bp_hold_A", A, 16'h000E);
    end
    @(posedge Clk); #1 rr_man = 1'b1;
    @(posedge Clk); #1;
    cmd_valid = 1'b0;
    chk("bp_release", {busy, rsp_valid, cmd_ready}, 3'b001);
    chk("bp_popped", got_q.size(), 1);

    // 4: timeout with no flags
    do_reset();
    force_mode = 1;
    send(16'h000E, 16'h0007, FUN_ADD, 1'b1);
    drain();
    chk("timeout_rsp", got_q[0], {2'b10, 16'h0000});

    // 5: reset mid-WAIT drops the op
    do_reset();
    send(16'h00AB, 16'h00CD, FUN_OR, 1'b0);
    chk("mid_wait_busy", busy, 1'b1);
    @(posedge Clk); #1 RST = 1'b0;
    #1 chk("mid_wait_reset", {A, B, ALU_FUN, rsp_valid, busy}, '0);
    repeat (2) @(posedge Clk);
    #1 RST = 1'b1;
    repeat (12) begin
      @(negedge Clk);
      chk("dropped_no_rsp", {rsp_valid, cmd_ready}, 2'b01);
    end

    // 6: wrong unit flag present -> timeout
    do_reset();
    force_mode = 2;
    send(16'hF0F0, 16'h0FF0, FUN_AND, 1'b1);
    drain();
    chk("mismatch_flag", got_q[0], {2'b10, 16'h0000});

    // 7: random traffic with random response backpressure
    do_reset();
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      f = 4'($urandom_range(0, 15));
      send(16'($urandom), 16'($urandom_range(0, 40)), f, 1'b1);
      repeat ($urandom_range(0, 3)) @(posedge Clk);
    end
    drain();
    chk("random_count", got_q.size(), 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
